// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller.
//   hz_state_e    : hazard FSM states
//   READMEM_NONE  : ex_readMem encoding for "not a load"
//   reg_match()   : source-register dependency test against an EX destination
package hazard_ctrl_pkg;

   typedef enum logic {
      HZ_RUN   = 1'b0,
      HZ_STALL = 1'b1
   } hz_state_e;

   localparam logic [2:0] READMEM_NONE = 3'b000;

   function automatic logic reg_match(input logic use_reg, input logic [4:0] src, input logic [4:0] rd);
      return use_reg && (src == rd);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle between the ID/EX stages and the hazard controller.
//   id_rs1/id_rs2, id_useRs1/id_useRs2 : operands read by the ID instruction
//   ex_rd, ex_writeReg, ex_readMem     : destination/load info of the EX instruction
//   ex_jump                            : redirect resolved in EX this cycle
//   pc_pause, if_id_pause, if_id_flush, id_ex_flush : stage-register controls
// master = pipeline side (drives stage info), slave = hazard controller.
interface hazard_ctrl_if;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_useRs1;
   logic       id_useRs2;
   logic [4:0] ex_rd;
   logic       ex_writeReg;
   logic [2:0] ex_readMem;
   logic       ex_jump;
   logic       pc_pause;
   logic       if_id_pause;
   logic       if_id_flush;
   logic       id_ex_flush;

   modport master (
      output id_rs1, id_rs2, id_useRs1, id_useRs2, ex_rd, ex_writeReg, ex_readMem, ex_jump,
      input  pc_pause, if_id_pause, if_id_flush, id_ex_flush
   );

   modport slave (
      input  id_rs1, id_rs2, id_useRs1, id_useRs2, ex_rd, ex_writeReg, ex_readMem, ex_jump,
      output pc_pause, if_id_pause, if_id_flush, id_ex_flush
   );
endinterface

// File: rtl/hazard_perf_cnt.sv
// Wrapping event counter for performance debug.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count this cycle
//   count    : running total, wraps modulo 2^CNT_W
module hazard_perf_cnt #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall and EX-redirect flush controller for the IF/ID and ID/EX
// stage registers and the PC.
//   clk, rst   : clock, synchronous active-high reset
//   pipe       : stage info in, pause/flush controls out (hazard_ctrl_if.slave)
//   stall_cnt  : cycles with pc_pause high
//   flush_cnt  : cycles with if_id_flush high (EX redirects)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// HZ_RUN   | normal flow; flush on ex_jump, else stall on a load-use hazard
// HZ_STALL | extra bubble cycles for LOAD_LATENCY>1; remain counts them down
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned LOAD_LATENCY = 1,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   hazard_ctrl_if.slave     pipe,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [1:0] REMAIN_LOAD = 2'(LOAD_LATENCY - 1);

   hz_state_e  state, state_nxt;
   logic [1:0] remain, remain_nxt;
   logic       hz;

   assign hz = (pipe.ex_readMem != READMEM_NONE) && pipe.ex_writeReg && (pipe.ex_rd != 5'd0) &&
               (reg_match(pipe.id_useRs1, pipe.id_rs1, pipe.ex_rd) ||
                reg_match(pipe.id_useRs2, pipe.id_rs2, pipe.ex_rd));

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= HZ_RUN;
         remain <= 2'd0;
      end else begin
         state  <= state_nxt;
         remain <= remain_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      remain_nxt       = remain;
      pipe.pc_pause    = 1'b0;
      pipe.if_id_pause = 1'b0;
      pipe.if_id_flush = 1'b0;
      pipe.id_ex_flush = 1'b0;
      if (!rst) begin
         case (state)
            HZ_RUN: begin
               // The ID instruction is on the wrong path when EX redirects,
               // so the flush wins over any hazard it appears to have.
               if (pipe.ex_jump) begin
                  pipe.if_id_flush = 1'b1;
                  pipe.id_ex_flush = 1'b1;
               end else if (hz) begin
                  pipe.pc_pause    = 1'b1;
                  pipe.if_id_pause = 1'b1;
                  pipe.id_ex_flush = 1'b1;
                  if (LOAD_LATENCY > 1) begin
                     remain_nxt = REMAIN_LOAD;
                     state_nxt  = HZ_STALL;
                  end
               end
            end
            HZ_STALL: begin
               // EX holds a bubble here, so hz is meaningless; only a stray
               // redirect can break the stall early.
               if (pipe.ex_jump) begin
                  pipe.if_id_flush = 1'b1;
                  pipe.id_ex_flush = 1'b1;
                  remain_nxt       = 2'd0;
                  state_nxt        = HZ_RUN;
               end else begin
                  pipe.pc_pause    = 1'b1;
                  pipe.if_id_pause = 1'b1;
                  pipe.id_ex_flush = 1'b1;
                  remain_nxt       = remain - 2'd1;
                  if (remain == 2'd1) begin
                     state_nxt = HZ_RUN;
                  end
               end
            end
            default: state_nxt = HZ_RUN;
         endcase
      end
   end

   hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (pipe.pc_pause),
      .count (stall_cnt)
   );

   hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (pipe.if_id_flush),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances share one stimulus stream
//   dut1 : LOAD_LATENCY=1, CNT_W=32
//   dut3 : LOAD_LATENCY=3, CNT_W=32
//   dut4 : LOAD_LATENCY=1, CNT_W=4 (counter wrap)
// Each vector carries hand-derived control outputs for the LL=1 and LL=3
// instances as {pc_pause, if_id_pause, if_id_flush, id_ex_flush}.
module tb_hazard_ctrl;

   localparam logic [3:0] P = 4'b1101;
   localparam logic [3:0] F = 4'b0011;
   localparam logic [3:0] N = 4'b0000;

   typedef struct {
      logic       rst;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       wr;
      logic [2:0] rm;
      logic       jmp;
      logic [3:0] e1;
      logic [3:0] e3;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hazard_ctrl_if if1 ();
   hazard_ctrl_if if3 ();
   hazard_ctrl_if if4 ();

   assign if3.id_rs1      = if1.id_rs1;
   assign if3.id_rs2      = if1.id_rs2;
   assign if3.id_useRs1   = if1.id_useRs1;
   assign if3.id_useRs2   = if1.id_useRs2;
   assign if3.ex_rd       = if1.ex_rd;
   assign if3.ex_writeReg = if1.ex_writeReg;
   assign if3.ex_readMem  = if1.ex_readMem;
   assign if3.ex_jump     = if1.ex_jump;
   assign if4.id_rs1      = if1.id_rs1;
   assign if4.id_rs2      = if1.id_rs2;
   assign if4.id_useRs1   = if1.id_useRs1;
   assign if4.id_useRs2   = if1.id_useRs2;
   assign if4.ex_rd       = if1.ex_rd;
   assign if4.ex_writeReg = if1.ex_writeReg;
   assign if4.ex_readMem  = if1.ex_readMem;
   assign if4.ex_jump     = if1.ex_jump;

   logic [31:0] st1, fl1, st3, fl3;
   logic [3:0]  st4, fl4;

   hazard_ctrl #(.LOAD_LATENCY(1), .CNT_W(32)) dut1 (
      .clk(clk), .rst(rst), .pipe(if1.slave), .stall_cnt(st1), .flush_cnt(fl1));
   hazard_ctrl #(.LOAD_LATENCY(3), .CNT_W(32)) dut3 (
      .clk(clk), .rst(rst), .pipe(if3.slave), .stall_cnt(st3), .flush_cnt(fl3));
   hazard_ctrl #(.LOAD_LATENCY(1), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .pipe(if4.slave), .stall_cnt(st4), .flush_cnt(fl4));

   int n_vec  = 0;
   int n_miss = 0;
   int idx    = 0;

   vec_t tbl[$];
   vec_t sb[$];
   vec_t cur;

   logic [31:0] e_st1 = 0, e_fl1 = 0, e_st3 = 0, e_fl3 = 0;
   logic [3:0]  e_st4 = 0, e_fl4 = 0;

   function automatic vec_t mk(logic r, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                               logic [4:0] rd, logic wr, logic [2:0] rm, logic jmp,
                               logic [3:0] e1, logic [3:0] e3);
      vec_t v;
      v.rst = r;  v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
      v.rd  = rd; v.wr  = wr;  v.rm  = rm;  v.jmp = jmp;
      v.e1  = e1; v.e3  = e3;
      return v;
   endfunction

   // standard load-use pattern: lw x5 in EX, ID reads x5 through rs2
   function automatic vec_t vh(logic r, logic jmp, logic [3:0] e1, logic [3:0] e3);
      return mk(r, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 3'b010, jmp, e1, e3);
   endfunction

   function automatic vec_t vi(logic [3:0] e1, logic [3:0] e3);
      return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0, e1, e3);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s (vector %0d): got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      @(negedge clk);
      rst             = v.rst;
      if1.id_rs1      = v.rs1;
      if1.id_rs2      = v.rs2;
      if1.id_useRs1   = v.u1;
      if1.id_useRs2   = v.u2;
      if1.ex_rd       = v.rd;
      if1.ex_writeReg = v.wr;
      if1.ex_readMem  = v.rm;
      if1.ex_jump     = v.jmp;
      sb.push_back(v);
   endtask

   // Scoreboard: outputs of the vector driven at this negedge, counters as
   // accumulated from every earlier vector since the last reset cycle.
   always @(negedge clk) begin
      #2;
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         check("ctrl_ll1", 32'({if1.pc_pause, if1.if_id_pause, if1.if_id_flush, if1.id_ex_flush}), 32'(cur.e1));
         check("ctrl_ll3", 32'({if3.pc_pause, if3.if_id_pause, if3.if_id_flush, if3.id_ex_flush}), 32'(cur.e3));
         check("ctrl_w4",  32'({if4.pc_pause, if4.if_id_pause, if4.if_id_flush, if4.id_ex_flush}), 32'(cur.e1));
         if (!cur.rst) begin
            check("stall_cnt_ll1", st1, e_st1);
            check("flush_cnt_ll1", fl1, e_fl1);
            check("stall_cnt_ll3", st3, e_st3);
            check("flush_cnt_ll3", fl3, e_fl3);
            check("stall_cnt_w4",  32'(st4), 32'(e_st4));
            check("flush_cnt_w4",  32'(fl4), 32'(e_fl4));
            e_st1 += 32'(cur.e1[3]);
            e_fl1 += 32'(cur.e1[1]);
            e_st3 += 32'(cur.e3[3]);
            e_fl3 += 32'(cur.e3[1]);
            e_st4 += 4'(cur.e1[3]);
            e_fl4 += 4'(cur.e1[1]);
         end else begin
            e_st1 = 0; e_fl1 = 0; e_st3 = 0; e_fl3 = 0; e_st4 = 0; e_fl4 = 0;
         end
         idx++;
      end
   end

   initial begin
      if1.id_rs1 = '0; if1.id_rs2 = '0; if1.id_useRs1 = 1'b0; if1.id_useRs2 = 1'b0;
      if1.ex_rd = '0; if1.ex_writeReg = 1'b0; if1.ex_readMem = '0; if1.ex_jump = 1'b0;

      // reset with a live hazard on the inputs
      tbl.push_back(vh(1'b1, 1'b0, N, N));
      tbl.push_back(vh(1'b1, 1'b0, N, N));
      tbl.push_back(vh(1'b1, 1'b0, N, N));
      tbl.push_back(vi(N, N));
      // load-use: LL=1 single bubble, LL=3 three bubbles ignoring inputs
      tbl.push_back(vh(1'b0, 1'b0, P, P));
      tbl.push_back(vi(N, P));
      tbl.push_back(vh(1'b0, 1'b0, P, P));
      tbl.push_back(vi(N, N));
      // false hazards: rd=x0, rs1 matches but unused, not a load, no write
      tbl.push_back(mk(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 3'b010, 1'b0, N, N));
      tbl.push_back(mk(1'b0, 5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 3'b010, 1'b0, N, N));
      tbl.push_back(mk(1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 3'b000, 1'b0, N, N));
      tbl.push_back(mk(1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 3'b010, 1'b0, N, N));
      // jump beats hazard
      tbl.push_back(vh(1'b0, 1'b1, F, F));
      tbl.push_back(vi(N, N));
      // hazard through rs1, then a jump aborting the LL=3 stall
      tbl.push_back(mk(1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 3'b001, 1'b0, P, P));
      tbl.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 3'b000, 1'b1, F, F));
      // back-to-back hazards with no gap cycle
      tbl.push_back(vh(1'b0, 1'b0, P, P));
      tbl.push_back(vh(1'b0, 1'b0, P, P));
      tbl.push_back(vh(1'b0, 1'b0, P, P));
      tbl.push_back(vh(1'b0, 1'b0, P, P));
      tbl.push_back(vi(N, P));
      tbl.push_back(vi(N, P));
      tbl.push_back(vi(N, N));
      // reset in the middle of an LL=3 stall
      tbl.push_back(vh(1'b0, 1'b0, P, P));
      tbl.push_back(vh(1'b1, 1'b0, N, N));
      tbl.push_back(vi(N, N));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
      end

      // jump priority from a clean reset: counters seen directly
      drive(vh(1'b1, 1'b0, N, N));
      drive(vh(1'b0, 1'b1, F, F));
      drive(vi(N, N));
      #3;
      check("prio_flush_cnt", fl1, 32'd1);
      check("prio_stall_cnt", st1, 32'd0);

      // 17 flushes on a 4-bit counter wrap to 1
      drive(vh(1'b1, 1'b0, N, N));
      for (int i = 0; i < 17; i++) begin
         drive(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 3'b000, 1'b1, F, F));
      end
      drive(vi(N, N));
      #3;
      check("wrap_flush_cnt", 32'(fl4), 32'd1);
      check("wide_flush_cnt", fl1, 32'd17);

      @(negedge clk);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
